// File: rtl/hilo_md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining HILO_MADD_EN.
module hilo_md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  input  logic        rd_hi,
  output logic [31:0] hilo_out,
  output logic        busy,
  output logic        md_stall
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef HILO_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      pend;
  logic             pend_we;

  logic is_mul;
  logic is_div;
  logic is_acc;
  logic is_md;

  assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
`ifdef HILO_MADD_EN
  assign is_acc = (md_op == OP_MADD) || (md_op == OP_MADDU) ||
                  (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`else
  assign is_acc = 1'b0;
`endif
  assign is_md = is_mul || is_div || is_acc;

  // Products: operands extended to 64 bits so the full product is kept.
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign a_sx   = $signed({{32{A[31]}}, A});
  assign b_sx   = $signed({{32{B[31]}}, B});
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'h0, A} * {32'h0, B};

  // Divisor is forced to 1 for zero/overflow cases so the divider never sees them.
  logic               b_zero;
  logic               div_ovf;
  logic signed [31:0] a_sg;
  logic signed [31:0] div_b_s;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] div_b_u;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign b_zero  = (B == 32'h0);
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign a_sg    = $signed(A);
  assign div_b_s = (b_zero || div_ovf) ? 32'sd1 : $signed(B);
  assign quo_s   = a_sg / div_b_s;
  assign rem_s   = a_sg % div_b_s;
  assign div_b_u = b_zero ? 32'd1 : B;
  assign quo_u   = A / div_b_u;
  assign rem_u   = A % div_b_u;

  logic [63:0] res;
  logic        res_we;

  always_comb begin
    res    = 64'h0;
    res_we = 1'b1;
    case (md_op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        if (b_zero)       res_we = 1'b0;
        else if (div_ovf) res    = {32'h0, 32'h8000_0000};
        else              res    = {rem_s, quo_s};
      end
      OP_DIVU: begin
        if (b_zero) res_we = 1'b0;
        else        res    = {rem_u, quo_u};
      end
`ifdef HILO_MADD_EN
      OP_MADD:  res = {hi, lo} + prod_s;
      OP_MADDU: res = {hi, lo} + prod_u;
      OP_MSUB:  res = {hi, lo} - prod_s;
      OP_MSUBU: res = {hi, lo} - prod_u;
`endif
      default:  res_we = 1'b0;
    endcase
  end

  logic [CNT_W-1:0] n_cycles;
  assign n_cycles = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // Result is captured at accept and committed to HI/LO when the counter expires.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi      <= 32'h0;
      lo      <= 32'h0;
      cnt     <= '0;
      pend    <= 64'h0;
      pend_we <= 1'b0;
      busy    <= 1'b0;
    end else if (busy) begin
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        if (pend_we) {hi, lo} <= pend;
      end
      cnt <= cnt - CNT_W'(1);
    end else if (!req) begin
      if (is_md) begin
        busy    <= 1'b1;
        cnt     <= n_cycles;
        pend    <= res;
        pend_we <= res_we;
      end else if (md_op == OP_MTHI) begin
        hi <= A;
      end else if (md_op == OP_MTLO) begin
        lo <= A;
      end
    end
  end

  assign hilo_out = rd_hi ? hi : lo;
  assign md_stall = busy || (is_md && !req);

endmodule
